// File: rtl/result_unloader_pkg.sv
// Shared harness package for the multiplier compressor test harness.
// Holds the capture/unload state encoding and the mul20 geometry constants
// used by both the input-side column loaders and the result unloader.
package result_unloader_pkg;

  // mul20: 2*20+1 result columns, tallest input column holds 20 bits.
  localparam int MUL20_NCOL           = 41;
  localparam int MUL20_MAX_COL_HEIGHT = 20;

  // Width of the settle-delay counter (CAP_DELAY range 0..255).
  localparam int DLY_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } unl_state_e;

endpackage

// File: rtl/result_unloader_piso_shift.sv
// piso_shift: W-wide parallel-load, shift-right register exposing bit 0.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (clears register)
//   load       - capture din (has priority over shift)
//   shift      - shift right by one, zero fill from the top
//   din        - parallel load data
//   bit0       - current LSB (registered)
module piso_shift #(
  parameter int W = 41
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         bit0
);

  logic [W-1:0] shreg_q;
  logic [W-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = din;
    end else if (shift) begin
      // Zero fill keeps bit0 low once every column has been sent.
      shreg_d = {1'b0, shreg_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign bit0 = shreg_q[0];

endmodule

// File: rtl/result_unloader.sv
// result_unloader: snapshots NCOL compressor result columns after a
// programmable settle delay and streams them LSB column first over a
// single-bit valid/ready link.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   start       - request capture-and-unload, honoured only in IDLE
//   dst         - parallel result columns, dst[i] = column i
//   sout        - current serial bit
//   sout_valid  - sout holds a valid column bit
//   sout_ready  - sink accepts the bit this cycle
//   sout_last   - high with the bit for column NCOL-1
//   busy        - high in every state except IDLE
//   done        - one-cycle pulse after the last bit is accepted
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_WAIT  | counting down the settle delay before capture
// ST_SHIFT | presenting shreg[0]; shift on each accepted transfer
// ST_DONE  | one-cycle done pulse, then back to IDLE
module result_unloader
  import result_unloader_pkg::*;
#(
  parameter int NCOL      = MUL20_NCOL,
  parameter int CAP_DELAY = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NCOL-1:0] dst,
  output logic            sout,
  output logic            sout_valid,
  input  logic            sout_ready,
  output logic            sout_last,
  output logic            busy,
  output logic            done
);

  localparam int                COL_W    = $clog2(NCOL);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(NCOL - 1);
  localparam logic [DLY_W-1:0]  DLY_LOAD = (CAP_DELAY > 0) ? DLY_W'(CAP_DELAY - 1) : '0;

  unl_state_e       state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load;
  logic             shift;

  piso_shift #(.W(NCOL)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (dst),
    .bit0  (sout)
  );

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    col_d   = col_q;
    load    = 1'b0;
    shift   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (CAP_DELAY > 0) begin
            dly_d   = DLY_LOAD;
            state_d = ST_WAIT;
          end else begin
            load    = 1'b1;
            col_d   = '0;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_WAIT: begin
        if (dly_q == '0) begin
          load    = 1'b1;
          col_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      ST_SHIFT: begin
        // In SHIFT sout_valid is always high, so ready alone marks a transfer.
        if (sout_ready) begin
          shift = 1'b1;
          if (col_q == COL_LAST) begin
            state_d = ST_DONE;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    valid_d = (state_d == ST_SHIFT);
    last_d  = (state_d == ST_SHIFT) && (col_d == COL_LAST);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sout_valid = valid_q;
  assign sout_last  = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/result_unloader.md
# result_unloader

Parallel-in/serial-out capture stage on the output side of the multiplier compressor test harness. It snapshots the compressor's NCOL one-bit result columns (dst0..dst(NCOL-1)) after a programmable settle delay, then streams them LSB-column-first over a single-bit valid/ready link. This lets a pin-limited bench or FPGA wrapper read back the full product serially, mirroring the serial column loaders on the input side.

## Interface
Parameters:
- NCOL, 41, number of result columns (2*20+1 for mul20); bit i of `dst` is column dst<i>
- CAP_DELAY, 0, cycles to wait between accepted `start` and capture (covers compressor pipeline latency); range 0..255

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset; one clock, one reset, no other clock domains
- start  input  1  request a capture-and-unload; honoured only in IDLE
- dst  input  NCOL  parallel compressor result columns, dst[i] = dst<i>[0]
- sout  output  1  current serial bit
- sout_valid  output  1  `sout` holds a valid column bit
- sout_ready  input  1  sink accepts the bit this cycle
- sout_last  output  1  high with the bit for column NCOL-1
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last bit is accepted

## Operation
- States: IDLE, WAIT, SHIFT, DONE.
- IDLE: busy=0. On `start`: go to WAIT if CAP_DELAY>0 and load delay counter with CAP_DELAY-1; otherwise capture `dst` into the shift register, clear the column counter, go to SHIFT.
- WAIT: decrement the delay counter each cycle. When it reads 0, capture `dst`, clear the column counter, go to SHIFT. `dst` is sampled only on the capture edge; later changes are ignored.
- SHIFT: sout_valid=1, sout=shreg[0], sout_last=(col==NCOL-1). On a transfer (sout_valid & sout_ready): shift right by one and increment col. A transfer with sout_last=1 goes to DONE. Without sout_ready, sout, sout_last and col hold indefinitely.
- DONE: done=1, busy=1, sout_valid=0 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored. It is not queued. This includes `start` in the cycle of the last transfer and in DONE.
- Column counter width is $clog2(NCOL). It never wraps, because SHIFT exits at NCOL-1.
- Delay counter width is 8 bits.

## Timing
- Reset values: sout=0, sout_valid=0, sout_last=0, busy=0, done=0, state=IDLE, shift register and counters 0.
- Reset while busy aborts immediately. The next cycle is IDLE with all outputs at reset values. No `done` is produced.
- `rst` has priority over `start` in the same cycle.
- Latency: `start` at cycle T in IDLE → capture at the end of cycle T+CAP_DELAY → first sout_valid in cycle T+CAP_DELAY+1.
- With sout_ready held high, NCOL bits are transferred on consecutive cycles. sout_last is asserted in cycle T+CAP_DELAY+NCOL, `done` in T+CAP_DELAY+NCOL+1, and IDLE (busy=0) in T+CAP_DELAY+NCOL+2.
- Minimum spacing between accepted starts is CAP_DELAY+NCOL+2 cycles.
- All outputs are registered; there is no combinational path from `dst` or `start` to any output.
- sout_ready-to-shift is the only input-to-state path within a cycle.

## Structure
- Shared package (the harness package used by the column loaders) holds:
  - the state enum (IDLE, WAIT, SHIFT, DONE);
  - the mul20 constants NCOL=41 and max column height 20.
- One sub-module is natural: `piso_shift` (NCOL-wide load/shift register with load and shift enables, exposing bit 0).
- FSM, counters and handshake stay in `result_unloader`.
- A thin harness-level wrapper concatenates the compressor's individual dst ports into `dst`. That wrapper is not part of this block.

## Test plan
- Reset, then idle for 10 cycles: all outputs 0; `start` asserted together with `rst` produces no activity.
- NCOL=41, CAP_DELAY=0, dst=41'h1_0000_0001, sout_ready=1, start at cycle 0:
  - sout_valid in cycles 1..41;
  - sout=1 only in cycles 1 and 33;
  - sout_last in cycle 41; done in cycle 42; busy=0 in cycle 43.
- CAP_DELAY=3, dst changes from 0 to 41'h1FF_FFFF_FFFF at cycle 2, start at cycle 0:
  - capture happens at the end of cycle 3, so all 41 bits read 1;
  - a second run with the change at cycle 4 reads all 0.
- Backpressure with dst=41'h155_5555_5555: toggle sout_ready 1,0,0,1,...
  - the sequence of accepted bits is 1,0,1,0,... with no bit skipped or repeated;
  - sout is stable while ready=0;
  - exactly 41 transfers occur.
- Ignored start: pulse `start` in SHIFT, on the last-transfer cycle and in DONE. The block returns to IDLE and stays there, with exactly one `done`.
- Reset mid-stream: assert rst after 20 transfers. Next cycle all outputs are 0 and no `done` follows. A fresh `start` then unloads the full 41 bits correctly.
